// File: rtl/sonic_sensor_array.sv
// Round-robin ultrasonic ranging controller: one trigger group fires at a time and
// every channel of that group measures its echo pulse width in whole centimetres.
module sonic_sensor_array #(
   parameter  int NUM_CH        = 6,
   parameter  int NUM_GROUPS    = 2,
   parameter  int DIST_W        = 9,
   parameter  int TRIG_CYCLES   = 500,
   parameter  int CYCLES_PER_CM = 2900,
   parameter  int LISTEN_CYCLES = 1900000,
   parameter  int GAP_CYCLES    = 500000,
   localparam int GIDX_W        = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
   input  logic                     CLOCK_50,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic                     single_shot,
   input  logic [NUM_CH-1:0]        echo,
   output logic [NUM_GROUPS-1:0]    trig,
   output logic [NUM_CH*DIST_W-1:0] dist_flat,
   output logic [NUM_CH-1:0]        dist_valid,
   output logic [NUM_CH-1:0]        no_echo,
   output logic [GIDX_W-1:0]        group_idx,
   output logic                     busy
);

   localparam int MAX_TL = (TRIG_CYCLES > LISTEN_CYCLES) ? TRIG_CYCLES : LISTEN_CYCLES;
   localparam int MAX_T  = (MAX_TL > GAP_CYCLES) ? MAX_TL : GAP_CYCLES;
   localparam int TMR_W  = $clog2(MAX_T + 1);
   localparam int PS_W   = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

   localparam logic [TMR_W-1:0]  TRIG_LAST   = TMR_W'(TRIG_CYCLES - 1);
   localparam logic [TMR_W-1:0]  LISTEN_LAST = TMR_W'(LISTEN_CYCLES - 1);
   localparam logic [TMR_W-1:0]  GAP_LAST    = TMR_W'(GAP_CYCLES - 1);
   localparam logic [PS_W-1:0]   PS_LAST     = PS_W'(CYCLES_PER_CM - 1);
   localparam logic [GIDX_W-1:0] GRP_LAST    = GIDX_W'(NUM_GROUPS - 1);
   localparam logic [DIST_W-1:0] NO_ECHO_VAL = '1;
   localparam logic [DIST_W-1:0] MAX_CM      = DIST_W'((1 << DIST_W) - 2);

   typedef enum logic [1:0] {S_IDLE, S_TRIG, S_LISTEN, S_GAP} sched_e;
   typedef enum logic [1:0] {CH_DONE, CH_ARMED, CH_MEASURE} ch_e;

   sched_e             state_q, state_d;
   logic [GIDX_W-1:0]  group_q, group_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               arm, listen, listen_last;

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         group_q <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         group_q <= group_d;
         timer_q <= timer_d;
      end
   end

   always_comb begin
      state_d = state_q;
      group_d = group_q;
      timer_d = timer_q + 1'b1;
      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (enable || single_shot) begin
               state_d = S_TRIG;
               group_d = '0;
            end
         end
         S_TRIG: begin
            if (timer_q == TRIG_LAST) begin
               state_d = S_LISTEN;
               timer_d = '0;
            end
         end
         S_LISTEN: begin
            if (timer_q == LISTEN_LAST) begin
               state_d = S_GAP;
               timer_d = '0;
            end
         end
         S_GAP: begin
            if (timer_q == GAP_LAST) begin
               timer_d = '0;
               if (group_q != GRP_LAST) begin
                  group_d = group_q + 1'b1;
                  state_d = S_TRIG;
               end else begin
                  // A sweep always completes; enable only decides whether another starts.
                  group_d = '0;
                  state_d = enable ? S_TRIG : S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            group_d = '0;
            timer_d = '0;
         end
      endcase
   end

   assign arm         = (state_q == S_TRIG) && (timer_q == TRIG_LAST);
   assign listen      = (state_q == S_LISTEN);
   assign listen_last = listen && (timer_q == LISTEN_LAST);
   assign busy        = (state_q != S_IDLE);
   assign group_idx   = group_q;

   for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_trig
      assign trig[gi] = (state_q == S_TRIG) && (group_q == GIDX_W'(gi));
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam logic [GIDX_W-1:0] MY_GRP = GIDX_W'(gi % NUM_GROUPS);

      logic              sync1_q, sync2_q, prev_q;
      logic              rise, fall, mine;
      ch_e               st_q, st_d;
      logic [PS_W-1:0]   ps_q, ps_d;
      logic [DIST_W-1:0] cm_q, cm_d, cm_inc;
      logic [DIST_W-1:0] dist_q, dist_d;
      logic              valid_q, valid_d;
      logic              noecho_q, noecho_d;

      assign mine   = (group_q == MY_GRP);
      assign rise   = sync2_q & ~prev_q;
      assign fall   = ~sync2_q & prev_q;
      // The falling-edge cycle still counts as a high cycle, so the result is floor(high/CPCM).
      assign cm_inc = (ps_q == PS_LAST && cm_q < MAX_CM) ? cm_q + 1'b1 : cm_q;

      always_ff @(posedge CLOCK_50 or negedge reset_n) begin
         if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            st_q     <= CH_DONE;
            ps_q     <= '0;
            cm_q     <= '0;
            dist_q   <= '0;
            valid_q  <= 1'b0;
            noecho_q <= 1'b0;
         end else begin
            sync1_q  <= echo[gi];
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            st_q     <= st_d;
            ps_q     <= ps_d;
            cm_q     <= cm_d;
            dist_q   <= dist_d;
            valid_q  <= valid_d;
            noecho_q <= noecho_d;
         end
      end

      always_comb begin
         st_d     = st_q;
         ps_d     = ps_q;
         cm_d     = cm_q;
         dist_d   = dist_q;
         valid_d  = 1'b0;
         noecho_d = noecho_q;
         if (arm && mine) begin
            st_d = CH_ARMED;
            ps_d = '0;
            cm_d = '0;
         end else if (listen && mine) begin
            case (st_q)
               CH_ARMED: begin
                  if (rise) begin
                     st_d = CH_MEASURE;
                     ps_d = '0;
                     cm_d = '0;
                  end
               end
               CH_MEASURE: begin
                  ps_d = (ps_q == PS_LAST) ? '0 : ps_q + 1'b1;
                  cm_d = cm_inc;
                  if (fall) begin
                     dist_d   = cm_inc;
                     valid_d  = 1'b1;
                     noecho_d = 1'b0;
                     st_d     = CH_DONE;
                  end
               end
               default: ;
            endcase
            if (listen_last && st_d != CH_DONE) begin
               dist_d   = NO_ECHO_VAL;
               valid_d  = 1'b1;
               noecho_d = 1'b1;
               st_d     = CH_DONE;
            end
         end
      end

      assign dist_flat[gi*DIST_W +: DIST_W] = dist_q;
      assign dist_valid[gi]                 = valid_q;
      assign no_echo[gi]                    = noecho_q;
   end

endmodule

// File: tb/tb_sonic_sensor_array.sv
// Directed bench for sonic_sensor_array using shortened timing; a second instance
// with DIST_W=6 covers saturation and truncation.
module tb_sonic_sensor_array;

   localparam int NCH = 6;
   localparam int DW  = 9;
   localparam int DW6 = 6;

   logic             clk = 1'b0;
   logic             reset_n = 1'b1;
   logic             enable = 1'b0;
   logic             single_shot = 1'b0;
   logic [NCH-1:0]   echo = '0;
   logic [NCH-1:0]   echo6 = '0;

   logic [1:0]       trig, trig6;
   logic [NCH*DW-1:0]  dist_flat;
   logic [NCH*DW6-1:0] dist6_flat;
   logic [NCH-1:0]   dist_valid, dist_valid6, no_echo, no_echo6;
   logic [0:0]       group_idx, group_idx6;
   logic             busy, busy6;

   int tests = 0;
   int failed = 0;
   int cyc = 0;
   int overlap = 0;
   int vcount [NCH] = '{default: 0};
   int rise_cyc [$];
   int rise_grp [$];
   logic [1:0] trig_prev = 2'b00;

   sonic_sensor_array #(
      .NUM_CH(NCH), .NUM_GROUPS(2), .DIST_W(DW), .TRIG_CYCLES(5),
      .CYCLES_PER_CM(10), .LISTEN_CYCLES(2000), .GAP_CYCLES(50)
   ) dut (
      .CLOCK_50(clk), .reset_n(reset_n), .enable(enable), .single_shot(single_shot),
      .echo(echo), .trig(trig), .dist_flat(dist_flat), .dist_valid(dist_valid),
      .no_echo(no_echo), .group_idx(group_idx), .busy(busy)
   );

   sonic_sensor_array #(
      .NUM_CH(NCH), .NUM_GROUPS(2), .DIST_W(DW6), .TRIG_CYCLES(5),
      .CYCLES_PER_CM(10), .LISTEN_CYCLES(2000), .GAP_CYCLES(50)
   ) dut6 (
      .CLOCK_50(clk), .reset_n(reset_n), .enable(enable), .single_shot(single_shot),
      .echo(echo6), .trig(trig6), .dist_flat(dist6_flat), .dist_valid(dist_valid6),
      .no_echo(no_echo6), .group_idx(group_idx6), .busy(busy6)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (trig[g] && !trig_prev[g]) begin
            rise_cyc.push_back(cyc);
            rise_grp.push_back(g);
         end
      end
      if (&trig) overlap <= overlap + 1;
      for (int c = 0; c < NCH; c++) begin
         if (dist_valid[c]) vcount[c] <= vcount[c] + 1;
      end
      trig_prev <= trig;
   end

   function automatic logic [DW-1:0] d9(input int c);
      return dist_flat[c*DW +: DW];
   endfunction

   function automatic logic [DW6-1:0] d6(input int c);
      return dist6_flat[c*DW6 +: DW6];
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      tick(3);
      tests++; if (trig !== 2'b00) begin failed++; $display("FAIL reset_trig: got %b expected 00", trig); end
      tests++; if (dist_flat !== '0) begin failed++; $display("FAIL reset_dist: got %h expected 0", dist_flat); end
      tests++; if (dist_valid !== '0 || no_echo !== '0) begin failed++; $display("FAIL reset_flags: valid=%b no_echo=%b expected 0", dist_valid, no_echo); end
      tests++; if (busy !== 1'b0 || group_idx !== 1'b0) begin failed++; $display("FAIL reset_busy: busy=%b group=%b expected 0", busy, group_idx); end
      reset_n = 1'b1;
      tick(5);
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL idle_after_reset: busy=%b expected 0", busy); end
      $display("[TB] test_reset done");
   endtask

   task automatic test_single_sweep();
      int n, hi, t_listen, r0, v0, v2;
      r0 = rise_cyc.size(); v0 = vcount[0]; v2 = vcount[2];
      single_shot = 1'b1; tick(1); single_shot = 1'b0;
      tests++; if (trig !== 2'b01 || busy !== 1'b1) begin failed++; $display("FAIL sweep_start: trig=%b busy=%b expected 01/1", trig, busy); end
      hi = 1;
      while (trig[0] === 1'b1 && hi < 50) begin
         tick(1);
         if (trig[0] === 1'b1) hi++;
      end
      tests++; if (hi != 5) begin failed++; $display("FAIL trig_width: got %0d expected 5", hi); end
      t_listen = cyc;
      tick(20); echo[0] = 1'b1; echo[4] = 1'b1;
      tick(50); echo[4] = 1'b0;
      tick(50); echo[0] = 1'b0;
      tick(2);
      tests++; if (dist_valid[0] !== 1'b0) begin failed++; $display("FAIL valid0_early: got %b expected 0", dist_valid[0]); end
      tick(1);
      tests++; if (dist_valid[0] !== 1'b1) begin failed++; $display("FAIL valid0_latency: got %b expected 1", dist_valid[0]); end
      tests++; if (d9(0) !== 9'd10) begin failed++; $display("FAIL dist0: got %0d expected 10", d9(0)); end
      tests++; if (no_echo[0] !== 1'b0) begin failed++; $display("FAIL no_echo0: got %b expected 0", no_echo[0]); end
      tests++; if (d9(4) !== 9'd5) begin failed++; $display("FAIL dist4_short: got %0d expected 5", d9(4)); end
      n = 0;
      while (dist_valid[2] !== 1'b1 && n < 2100) begin tick(1); n++; end
      tests++; if (dist_valid[2] !== 1'b1 || (cyc - t_listen) != 2000) begin failed++; $display("FAIL timeout2_time: got %0d expected 2000", cyc - t_listen); end
      tests++; if (d9(2) !== 9'd511) begin failed++; $display("FAIL dist2_timeout: got %0d expected 511", d9(2)); end
      tests++; if (no_echo[2] !== 1'b1) begin failed++; $display("FAIL no_echo2: got %b expected 1", no_echo[2]); end
      tests++; if (d9(1) !== 9'd0) begin failed++; $display("FAIL dist1_hold: got %0d expected 0", d9(1)); end
      n = 0;
      while (busy !== 1'b0 && n < 5000) begin tick(1); n++; end
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL sweep_end: busy=%b expected 0", busy); end
      tests++; if (vcount[0] - v0 != 1 || vcount[2] - v2 != 1) begin failed++; $display("FAIL valid_pulses: ch0=%0d ch2=%0d expected 1/1", vcount[0] - v0, vcount[2] - v2); end
      tests++; if (rise_cyc.size() - r0 != 2) begin failed++; $display("FAIL sweep_trigs: got %0d expected 2", rise_cyc.size() - r0); end
      tests++; if (no_echo[1] !== 1'b1 || d9(1) !== 9'd511) begin failed++; $display("FAIL group1_timeout: no_echo=%b dist=%0d expected 1/511", no_echo[1], d9(1)); end
      $display("[TB] test_single_sweep done");
   endtask

   task automatic test_saturation();
      int n;
      single_shot = 1'b1; tick(1); single_shot = 1'b0;
      n = 0;
      while (trig6[1] !== 1'b1 && n < 3000) begin tick(1); n++; end
      tests++; if (trig6[1] !== 1'b1) begin failed++; $display("FAIL sat_group1_trig: got %b expected 1", trig6[1]); end
      n = 0;
      while (trig6[1] !== 1'b0 && n < 20) begin tick(1); n++; end
      tick(10); echo6[1] = 1'b1; echo6[3] = 1'b1;
      tick(129); echo6[3] = 1'b0;
      tick(871); echo6[1] = 1'b0;
      n = 0;
      while (busy6 !== 1'b0 && n < 3000) begin tick(1); n++; end
      tests++; if (busy6 !== 1'b0) begin failed++; $display("FAIL sat_end: busy=%b expected 0", busy6); end
      tests++; if (d6(1) !== 6'd62 || no_echo6[1] !== 1'b0) begin failed++; $display("FAIL dist1_sat: got %0d/%b expected 62/0", d6(1), no_echo6[1]); end
      tests++; if (d6(3) !== 6'd12 || no_echo6[3] !== 1'b0) begin failed++; $display("FAIL dist3_trunc: got %0d/%b expected 12/0", d6(3), no_echo6[3]); end
      tests++; if (d6(0) !== 6'd63 || no_echo6[0] !== 1'b1) begin failed++; $display("FAIL dist0_noecho6: got %0d/%b expected 63/1", d6(0), no_echo6[0]); end
      $display("[TB] test_saturation done");
   endtask

   task automatic test_continuous();
      int n, r0, ov0;
      r0 = rise_cyc.size(); ov0 = overlap;
      enable = 1'b1;
      n = 0;
      while (rise_cyc.size() < r0 + 6 && n < 13000) begin tick(1); n++; end
      tests++; if (rise_cyc.size() < r0 + 6) begin failed++; $display("FAIL cont_trigs: got %0d expected 6", rise_cyc.size() - r0); end
      else begin
         for (int i = 0; i < 6; i++) begin
            tests++; if (rise_grp[r0+i] != i % 2) begin failed++; $display("FAIL cont_group%0d: got %0d expected %0d", i, rise_grp[r0+i], i % 2); end
         end
         for (int i = 0; i < 5; i++) begin
            tests++; if (rise_cyc[r0+i+1] - rise_cyc[r0+i] != 2055) begin failed++; $display("FAIL cont_spacing%0d: got %0d expected 2055", i, rise_cyc[r0+i+1] - rise_cyc[r0+i]); end
         end
      end
      n = 0;
      while (rise_cyc.size() < r0 + 7 && n < 2200) begin tick(1); n++; end
      tick(100);
      enable = 1'b0;
      n = 0;
      while (busy !== 1'b0 && n < 5000) begin tick(1); n++; end
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL cont_stop: busy=%b expected 0", busy); end
      tests++; if (rise_cyc.size() != r0 + 8) begin failed++; $display("FAIL cont_final_trigs: got %0d expected 8", rise_cyc.size() - r0); end
      else begin
         tests++; if (rise_grp[r0+7] != 1) begin failed++; $display("FAIL cont_last_group: got %0d expected 1", rise_grp[r0+7]); end
      end
      tick(100);
      tests++; if (busy !== 1'b0 || rise_cyc.size() != r0 + 8) begin failed++; $display("FAIL cont_stays_idle: busy=%b trigs=%0d expected 0/8", busy, rise_cyc.size() - r0); end
      tests++; if (overlap != ov0) begin failed++; $display("FAIL trig_overlap: got %0d expected 0", overlap - ov0); end
      $display("[TB] test_continuous done");
   endtask

   task automatic test_echo_preheld();
      int n, r0, v4;
      echo[4] = 1'b1;
      tick(5);
      r0 = rise_cyc.size(); v4 = vcount[4];
      single_shot = 1'b1; tick(1); single_shot = 1'b0;
      n = 0;
      while (trig[0] === 1'b1 && n < 20) begin tick(1); n++; end
      tick(100);
      single_shot = 1'b1; tick(1); single_shot = 1'b0;
      n = 0;
      while (dist_valid[4] !== 1'b1 && n < 2100) begin tick(1); n++; end
      tests++; if (dist_valid[4] !== 1'b1) begin failed++; $display("FAIL preheld_valid: got %b expected 1", dist_valid[4]); end
      tests++; if (d9(4) !== 9'd511 || no_echo[4] !== 1'b1) begin failed++; $display("FAIL preheld_dist4: got %0d/%b expected 511/1", d9(4), no_echo[4]); end
      echo[4] = 1'b0;
      n = 0;
      while (busy !== 1'b0 && n < 5000) begin tick(1); n++; end
      tick(100);
      tests++; if (busy !== 1'b0 || rise_cyc.size() - r0 != 2) begin failed++; $display("FAIL shot_while_busy: busy=%b trigs=%0d expected 0/2", busy, rise_cyc.size() - r0); end
      tests++; if (vcount[4] - v4 != 1) begin failed++; $display("FAIL preheld_pulses: got %0d expected 1", vcount[4] - v4); end
      $display("[TB] test_echo_preheld done");
   endtask

   task automatic test_reset_mid();
      int n;
      enable = 1'b1;
      n = 0;
      while (trig[0] !== 1'b1 && n < 100) begin tick(1); n++; end
      n = 0;
      while (trig[0] !== 1'b0 && n < 20) begin tick(1); n++; end
      tick(20); echo[0] = 1'b1;
      n = 0;
      while (trig[1] !== 1'b1 && n < 2200) begin tick(1); n++; end
      tick(2);
      tests++; if (trig !== 2'b10 || group_idx !== 1'b1) begin failed++; $display("FAIL pre_reset: trig=%b group=%b expected 10/1", trig, group_idx); end
      reset_n = 1'b0;
      #1;
      tests++; if (trig !== 2'b00 || busy !== 1'b0 || group_idx !== 1'b0) begin failed++; $display("FAIL async_reset_ctrl: trig=%b busy=%b group=%b expected 0", trig, busy, group_idx); end
      tests++; if (dist_flat !== '0 || dist6_flat !== '0) begin failed++; $display("FAIL async_reset_dist: got %h/%h expected 0", dist_flat, dist6_flat); end
      tests++; if (no_echo !== '0 || dist_valid !== '0) begin failed++; $display("FAIL async_reset_flags: no_echo=%b valid=%b expected 0", no_echo, dist_valid); end
      enable = 1'b0; echo = '0;
      tick(3);
      reset_n = 1'b1;
      tick(50);
      tests++; if (busy !== 1'b0 || trig !== 2'b00) begin failed++; $display("FAIL post_reset_idle: busy=%b trig=%b expected 0/00", busy, trig); end
      single_shot = 1'b1; tick(1); single_shot = 1'b0;
      tests++; if (trig !== 2'b01) begin failed++; $display("FAIL post_reset_shot: trig=%b expected 01", trig); end
      n = 0;
      while (busy !== 1'b0 && n < 5000) begin tick(1); n++; end
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL post_reset_end: busy=%b expected 0", busy); end
      $display("[TB] test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_single_sweep();
      test_saturation();
      test_continuous();
      test_echo_preheld();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
